// File: rtl/poly_score_sequencer_if.sv
// Score ROM bus between poly_score_sequencer (master) and a shared synchronous ROM (slave).
interface poly_score_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 24
);
  // No valid/ready pair: rom_addr carries a real request only in a grant cycle (it
  // reads 0 otherwise), and the slave must return that word on rom_data exactly one clk later.
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/poly_score_sequencer.sv
// Multi-voice score player: CHANNELS per-channel FSMs share one synchronous score ROM
// through a round-robin arbiter, paced by an internal millisecond prescaler.
module poly_score_sequencer #(
  parameter int CHANNELS = 2,
  parameter int PTR_W    = 8,
  parameter int LEN_W    = 16,
  parameter int TICK_DIV = 100000,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W   = $clog2(TICK_DIV)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      loop,
  input  logic                      restart,
  poly_score_sequencer_if.master    rom,
  output logic [4*CHANNELS-1:0]     note,
  output logic [4*CHANNELS-1:0]     octave,
  output logic [PTR_W*CHANNELS-1:0] note_pointer,
  output logic [CHANNELS-1:0]       active,
  output logic                      done,
  output logic [3*CHANNELS-1:0]     state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_DONE} state_e;

  state_e           state_q [CHANNELS];
  state_e           state_d [CHANNELS];
  logic [PTR_W-1:0] ptr_q   [CHANNELS];
  logic [PTR_W-1:0] ptr_d   [CHANNELS];
  logic [LEN_W-1:0] rem_q   [CHANNELS];
  logic [LEN_W-1:0] rem_d   [CHANNELS];
  logic [3:0]       note_q  [CHANNELS];
  logic [3:0]       note_d  [CHANNELS];
  logic [3:0]       oct_q   [CHANNELS];
  logic [3:0]       oct_d   [CHANNELS];
  logic [PTR_W-1:0] np_q    [CHANNELS];
  logic [PTR_W-1:0] np_d    [CHANNELS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d, tick;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CH_W-1:0]  tag_q, tag_d;
  logic             tag_vld_q, tag_vld_d;
  logic             done_q, done_d;
  logic             all_done;
  logic             gnt_vld;
  logic [CH_W-1:0]  gnt_ch;

  logic [3:0]       rd_oct, rd_note;
  logic [LEN_W-1:0] rd_len;

  assign rd_oct  = rom.rom_data[LEN_W+7 -: 4];
  assign rd_note = rom.rom_data[LEN_W+3 -: 4];
  assign rd_len  = rom.rom_data[LEN_W-1:0];

  // Round-robin: search starts one past the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!gnt_vld && state_q[(int'(last_q) + i) % CHANNELS] == S_FETCH) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'((int'(last_q) + i) % CHANNELS);
      end
    end
  end

  assign rom.rom_addr = gnt_vld ? {gnt_ch, ptr_q[gnt_ch]} : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    note_d    = note_q;
    oct_d     = oct_q;
    np_d      = np_q;
    cnt_d     = cnt_q;
    tick_d    = tick_q;
    last_d    = gnt_vld ? gnt_ch : last_q;
    tag_d     = gnt_ch;
    tag_vld_d = gnt_vld;
    all_done  = 1'b1;

    // A pending tick is held across a pause rather than dropped.
    if (en) begin
      tick_d = (cnt_q == CNT_W'(TICK_DIV - 1));
      cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end
    tick = tick_q & en;

    for (int c = 0; c < CHANNELS; c++) begin
      case (state_q[c])
        S_IDLE:  if (en) state_d[c] = S_FETCH;
        S_FETCH: if (gnt_vld && gnt_ch == CH_W'(c)) state_d[c] = S_WAIT;
        S_WAIT: begin
          if (tag_vld_q && tag_q == CH_W'(c)) begin
            if (rd_len != '0) begin
              note_d[c]  = rd_note;
              oct_d[c]   = rd_oct;
              rem_d[c]   = rd_len;
              np_d[c]    = ptr_q[c];
              state_d[c] = S_PLAY;
            end else if (loop && ptr_q[c] != '0) begin
              ptr_d[c]   = '0;
              state_d[c] = S_FETCH;
            end else begin
              note_d[c]  = 4'd0;
              oct_d[c]   = 4'd0;
              state_d[c] = S_DONE;
            end
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (rem_q[c] == LEN_W'(1)) begin
              ptr_d[c]   = ptr_q[c] + PTR_W'(1);
              state_d[c] = S_FETCH;
            end else begin
              rem_d[c] = rem_q[c] - LEN_W'(1);
            end
          end
        end
        S_DONE:  ;
        default: state_d[c] = S_IDLE;
      endcase
      if (state_q[c] != S_DONE) all_done = 1'b0;
    end
    done_d = all_done;

    // Restart also clears the tag, so a ROM word already in flight is never captured.
    if (restart) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_d[c] = S_IDLE;
        ptr_d[c]   = '0;
        rem_d[c]   = '0;
        note_d[c]  = 4'd0;
        oct_d[c]   = 4'd0;
        np_d[c]    = '0;
      end
      cnt_d     = '0;
      tick_d    = 1'b0;
      last_d    = CH_W'(CHANNELS - 1);
      tag_vld_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        ptr_q[c]   <= '0;
        rem_q[c]   <= '0;
        note_q[c]  <= 4'd0;
        oct_q[c]   <= 4'd0;
        np_q[c]    <= '0;
      end
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      last_q    <= CH_W'(CHANNELS - 1);
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      note_q    <= note_d;
      oct_q     <= oct_d;
      np_q      <= np_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      last_q    <= last_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      done_q    <= done_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign note[4*c +: 4]                = note_q[c];
    assign octave[4*c +: 4]              = oct_q[c];
    assign note_pointer[PTR_W*c +: PTR_W] = np_q[c];
    assign state_dbg[3*c +: 3]           = state_q[c];
    assign active[c] = (state_q[c] == S_FETCH) || (state_q[c] == S_WAIT) ||
                       (state_q[c] == S_PLAY);
  end

  assign done = done_q;

endmodule

// File: tb/tb_poly_score_sequencer.sv
// Directed bench for poly_score_sequencer: 2 channels, 4-clk tick, cycle-exact checks
// against hand-derived timelines (cycle 0 = first cycle after reset release with en=1).
module tb_poly_score_sequencer;
  localparam int CHANNELS = 2;
  localparam int PTR_W    = 8;
  localparam int LEN_W    = 16;
  localparam int TICK_DIV = 4;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 24;

  logic        clk, rst, en, loop, restart;
  logic [7:0]  note, octave;
  logic [15:0] note_pointer;
  logic [1:0]  active;
  logic        done;
  logic [5:0]  state_dbg;
  logic [DATA_W-1:0] mem [0:511];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  poly_score_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

  poly_score_sequencer #(
    .CHANNELS(CHANNELS), .PTR_W(PTR_W), .LEN_W(LEN_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .loop(loop), .restart(restart),
    .rom(rif), .note(note), .octave(octave), .note_pointer(note_pointer),
    .active(active), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block and synchronous ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rif.rom_data <= mem[rif.rom_addr];

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step(1);
  endtask

  function automatic logic [23:0] ent(input logic [3:0] o, input logic [3:0] n,
                                      input logic [15:0] l);
    return {o, n, l};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) mem[i] = '0;
  endtask

  task automatic load_base_rom();
    clear_rom();
    mem[0]   = ent(4'd4, 4'd1, 16'd3);
    mem[1]   = ent(4'd4, 4'd5, 16'd2);
    mem[256] = ent(4'd3, 4'd8, 16'd5);
  endtask

  task automatic start(input logic lp);
    rst = 1'b1; en = 1'b0; restart = 1'b0; loop = lp;
    step(2);
    rst = 1'b0; en = 1'b1;
    cyc = 0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0; en = 1'b0; loop = 1'b0; restart = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({note, octave, note_pointer} !== 32'h0) $display("FAIL reset_notes: got %h want 0", {note, octave, note_pointer}); else passed++;
    checks++; if ({active, done, rif.rom_addr} !== 12'h0) $display("FAIL reset_ctrl: got %h want 0", {active, done, rif.rom_addr}); else passed++;
    checks++; if (state_dbg !== 6'h0) $display("FAIL reset_state: got %h want 0", state_dbg); else passed++;
  endtask

  task automatic test_first_fetch();
    load_base_rom();
    start(1'b0);
    run_to(1);
    checks++; if (rif.rom_addr !== 9'h000) $display("FAIL ff_addr_c1: got %h want 000", rif.rom_addr); else passed++;
    checks++; if (active !== 2'b11) $display("FAIL ff_active_c1: got %b want 11", active); else passed++;
    run_to(2);
    checks++; if (rif.rom_addr !== 9'h100) $display("FAIL ff_addr_c2: got %h want 100", rif.rom_addr); else passed++;
    checks++; if (note !== 8'h00) $display("FAIL ff_note_c2: got %h want 00", note); else passed++;
    run_to(3);
    checks++; if ({octave[3:0], note[3:0]} !== 8'h41) $display("FAIL ff_ch0_c3: got %h want 41", {octave[3:0], note[3:0]}); else passed++;
    run_to(4);
    checks++; if ({octave[7:4], note[7:4]} !== 8'h38) $display("FAIL ff_ch1_c4: got %h want 38", {octave[7:4], note[7:4]}); else passed++;
    checks++; if (active !== 2'b11) $display("FAIL ff_active_c4: got %b want 11", active); else passed++;
  endtask

  // Continues the run started by test_first_fetch.
  task automatic test_length();
    run_to(14);
    checks++; if ({note[3:0], note_pointer[7:0]} !== 12'h100) $display("FAIL len_hold_c14: got %h want 100", {note[3:0], note_pointer[7:0]}); else passed++;
    run_to(15);
    checks++; if ({note[3:0], note_pointer[7:0]} !== 12'h501) $display("FAIL len_next_c15: got %h want 501", {note[3:0], note_pointer[7:0]}); else passed++;
    run_to(21);
    checks++; if (rif.rom_addr !== 9'h101) $display("FAIL len_rr_addr_c21: got %h want 101", rif.rom_addr); else passed++;
    run_to(22);
    checks++; if (rif.rom_addr !== 9'h002) $display("FAIL len_rr_addr_c22: got %h want 002", rif.rom_addr); else passed++;
    checks++; if (state_dbg !== 6'b010_001) $display("FAIL len_state_c22: got %b want 010001", state_dbg); else passed++;
    run_to(23);
    checks++; if ({note[7:4], octave[7:4], active} !== 10'b0000_0000_01) $display("FAIL len_ch1_done_c23: got %b want 0000000001", {note[7:4], octave[7:4], active}); else passed++;
    run_to(24);
    checks++; if ({note[3:0], active, done} !== 7'b0) $display("FAIL len_ch0_done_c24: got %b want 0000000", {note[3:0], active, done}); else passed++;
    run_to(25);
    checks++; if (done !== 1'b1) $display("FAIL len_done_c25: got %b want 1", done); else passed++;
  endtask

  task automatic test_loop();
    load_base_rom();
    start(1'b1);
    run_to(23);
    checks++; if (rif.rom_addr !== 9'h100) $display("FAIL loop_addr_c23: got %h want 100", rif.rom_addr); else passed++;
    run_to(24);
    checks++; if (rif.rom_addr !== 9'h000) $display("FAIL loop_addr_c24: got %h want 000", rif.rom_addr); else passed++;
    run_to(25);
    checks++; if (note[7:4] !== 4'd8) $display("FAIL loop_ch1_c25: got %h want 8", note[7:4]); else passed++;
    run_to(26);
    checks++; if ({octave[3:0], note[3:0], note_pointer[7:0], done} !== 17'h08200) $display("FAIL loop_ch0_c26: got %h want 08200", {octave[3:0], note[3:0], note_pointer[7:0], done}); else passed++;
    run_to(39);
    checks++; if ({note[3:0], note_pointer[7:0]} !== 12'h501) $display("FAIL loop_again_c39: got %h want 501", {note[3:0], note_pointer[7:0]}); else passed++;
  endtask

  task automatic test_empty_track();
    clear_rom();
    start(1'b1);
    run_to(3);
    checks++; if (active !== 2'b10) $display("FAIL empty_active_c3: got %b want 10", active); else passed++;
    run_to(4);
    checks++; if ({active, done} !== 3'b000) $display("FAIL empty_c4: got %b want 000", {active, done}); else passed++;
    run_to(5);
    checks++; if (done !== 1'b1) $display("FAIL empty_done_c5: got %b want 1", done); else passed++;
    checks++; if (state_dbg !== 6'b100_100) $display("FAIL empty_state_c5: got %b want 100100", state_dbg); else passed++;
  endtask

  task automatic test_pause();
    load_base_rom();
    start(1'b0);
    run_to(5);
    en = 1'b0;
    run_to(25);
    checks++; if ({note, octave, note_pointer} !== 32'h8134_0000) $display("FAIL pause_hold_c25: got %h want 81340000", {note, octave, note_pointer}); else passed++;
    checks++; if (active !== 2'b11) $display("FAIL pause_active_c25: got %b want 11", active); else passed++;
    en = 1'b1;
    run_to(34);
    checks++; if (note[3:0] !== 4'd1) $display("FAIL pause_hold_c34: got %h want 1", note[3:0]); else passed++;
    run_to(35);
    checks++; if ({note[3:0], note_pointer[7:0]} !== 12'h501) $display("FAIL pause_next_c35: got %h want 501", {note[3:0], note_pointer[7:0]}); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_rom();
    mem[0]   = ent(4'd2, 4'd3, 16'd2);
    mem[1]   = ent(4'd5, 4'd6, 16'd1);
    mem[256] = ent(4'd1, 4'd9, 16'd2);
    mem[257] = ent(4'd7, 4'd10, 16'd1);
    start(1'b0);
    run_to(9);
    checks++; if ({state_dbg, rif.rom_addr} !== {6'b001_001, 9'h001}) $display("FAIL b2b_c9: got %h want %h", {state_dbg, rif.rom_addr}, {6'b001_001, 9'h001}); else passed++;
    run_to(10);
    checks++; if (rif.rom_addr !== 9'h101) $display("FAIL b2b_addr_c10: got %h want 101", rif.rom_addr); else passed++;
    run_to(11);
    checks++; if ({octave[3:0], note[3:0], note_pointer[7:0]} !== 16'h5601) $display("FAIL b2b_ch0_c11: got %h want 5601", {octave[3:0], note[3:0], note_pointer[7:0]}); else passed++;
    run_to(12);
    checks++; if ({octave[7:4], note[7:4], note_pointer[15:8]} !== 16'h7A01) $display("FAIL b2b_ch1_c12: got %h want 7a01", {octave[7:4], note[7:4], note_pointer[15:8]}); else passed++;
  endtask

  task automatic test_restart();
    load_base_rom();
    start(1'b0);
    run_to(3);
    checks++; if (state_dbg !== 6'b010_011) $display("FAIL rs_state_c3: got %b want 010011", state_dbg); else passed++;
    restart = 1'b1;
    run_to(4);
    restart = 1'b0;
    checks++; if ({note, octave, note_pointer} !== 32'h0) $display("FAIL rs_clear_c4: got %h want 0", {note, octave, note_pointer}); else passed++;
    checks++; if ({active, done, rif.rom_addr} !== 12'h0) $display("FAIL rs_ctrl_c4: got %h want 0", {active, done, rif.rom_addr}); else passed++;
    run_to(5);
    checks++; if (rif.rom_addr !== 9'h000) $display("FAIL rs_addr_c5: got %h want 000", rif.rom_addr); else passed++;
    run_to(6);
    checks++; if (rif.rom_addr !== 9'h100) $display("FAIL rs_addr_c6: got %h want 100", rif.rom_addr); else passed++;
    run_to(7);
    checks++; if ({octave[3:0], note[3:0]} !== 8'h41) $display("FAIL rs_ch0_c7: got %h want 41", {octave[3:0], note[3:0]}); else passed++;
    run_to(8);
    checks++; if (note[7:4] !== 4'd8) $display("FAIL rs_ch1_c8: got %h want 8", note[7:4]); else passed++;
    run_to(18);
    checks++; if (note[3:0] !== 4'd1) $display("FAIL rs_hold_c18: got %h want 1", note[3:0]); else passed++;
    run_to(19);
    checks++; if (note[3:0] !== 4'd5) $display("FAIL rs_next_c19: got %h want 5", note[3:0]); else passed++;
  endtask

  task automatic test_async_reset();
    load_base_rom();
    start(1'b0);
    run_to(6);
    checks++; if (note !== 8'h81) $display("FAIL ar_before: got %h want 81", note); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if ({note, octave, note_pointer} !== 32'h0) $display("FAIL ar_clear: got %h want 0", {note, octave, note_pointer}); else passed++;
    checks++; if ({active, done} !== 3'b000) $display("FAIL ar_ctrl: got %b want 000", {active, done}); else passed++;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_length();
    test_loop();
    test_empty_track();
    test_pause();
    test_back_to_back();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
